// File: rtl/ex_stage.sv
// Execute stage: ALU decode, 16-bit ALU and the EX/MEM pipeline register.
// Define EX_MULDIV_EN to build the signed multiplier and divider.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  alu_op,
  input  logic [3:0]  funct,
  input  logic        alu_src,
  input  logic [15:0] rd1,
  input  logic [15:0] rd2,
  input  logic [15:0] imm,
  input  logic [3:0]  reg_rd,
  input  logic [3:0]  reg_rt,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic        r15_in,
  input  logic        regwrite_in,
  input  logic        flush_ex,
  output logic [3:0]  operation,
  output logic [15:0] alu_result_out,
  output logic [15:0] alu_remainder_out,
  output logic        overflow_out,
  output logic [3:0]  mov_op_out,
  output logic [3:0]  exm_reg_rd_out,
  output logic        memtoreg_out,
  output logic        memwrite_out,
  output logic        memread_out,
  output logic        r15_out,
  output logic        regwrite_out
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h8;
  localparam logic [3:0] OP_SRL = 4'h9;
  localparam logic [3:0] OP_SRA = 4'hA;
  localparam logic [3:0] OP_ROL = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic [15:0] a, b, sum, diff, rol;
  logic [3:0]  sh;
  logic [15:0] res, rem;
  logic        ovf;

  assign a    = rd1;
  assign b    = alu_src ? imm : rd2;
  assign sh   = b[3:0];
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    operation = OP_NOP;
    unique case (alu_op)
      2'b00: operation = OP_ADD;
      2'b01: operation = OP_SUB;
      2'b11: operation = OP_MOV;
      2'b10: begin
        case (funct)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_SLL, OP_SRL, OP_SRA, OP_ROL,
          OP_MOV: operation = funct;
`ifdef EX_MULDIV_EN
          OP_MUL, OP_DIV: operation = funct;
`endif
          default: operation = OP_NOP;
        endcase
      end
    endcase
  end

  // Bit i of the rotate comes from bit (i - sh) mod 16.
  always_comb begin
    rol = '0;
    for (int i = 0; i < 16; i++)
      rol[i] = a[4'(i) - sh];
  end

`ifdef EX_MULDIV_EN
  logic signed [15:0] sa, sb, quo, mod;
  logic signed [31:0] prod;
  logic               div_zero, div_ovf;

  assign sa       = $signed(a);
  assign sb       = $signed(b);
  assign prod     = sa * sb;
  assign div_zero = (b == 16'h0000);
  assign div_ovf  = (a == 16'h8000) && (b == 16'hFFFF);

  always_comb begin
    quo = '0;
    mod = '0;
    if (!div_zero && !div_ovf) begin
      quo = sa / sb;
      mod = sa % sb;
    end
  end
`endif

  always_comb begin
    res = '0;
    rem = '0;
    ovf = 1'b0;
    case (operation)
      OP_ADD: begin
        res = sum;
        ovf = (a[15] == b[15]) && (sum[15] != a[15]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
`ifdef EX_MULDIV_EN
      OP_MUL: begin
        res = prod[15:0];
        rem = prod[31:16];
        ovf = (prod[31:15] != {17{prod[15]}});
      end
      OP_DIV: begin
        res = div_ovf ? 16'h8000 : quo;
        rem = mod;
        ovf = div_zero || div_ovf;
      end
`endif
      OP_SLL: res = a << sh;
      OP_SRL: res = a >> sh;
      OP_SRA: res = $signed(a) >>> sh;
      OP_ROL: res = rol;
      OP_MOV: res = b;
      default: ;
    endcase
  end

  // A flush keeps data and tags but kills control bits and overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_out    <= '0;
      alu_remainder_out <= '0;
      overflow_out      <= 1'b0;
      mov_op_out        <= '0;
      exm_reg_rd_out    <= '0;
      memtoreg_out      <= 1'b0;
      memwrite_out      <= 1'b0;
      memread_out       <= 1'b0;
      r15_out           <= 1'b0;
      regwrite_out      <= 1'b0;
    end else begin
      alu_result_out    <= res;
      alu_remainder_out <= rem;
      overflow_out      <= ovf & ~flush_ex;
      mov_op_out        <= reg_rt;
      exm_reg_rd_out    <= reg_rd;
      memtoreg_out      <= memtoreg_in & ~flush_ex;
      memwrite_out      <= memwrite_in & ~flush_ex;
      memread_out       <= memread_in & ~flush_ex;
      r15_out           <= r15_in & ~flush_ex;
      regwrite_out      <= regwrite_in & ~flush_ex;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus random ops against
// an integer-arithmetic reference model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alu_op;
  logic [3:0]  funct;
  logic        alu_src;
  logic [15:0] rd1, rd2, imm;
  logic [3:0]  reg_rd, reg_rt;
  logic        memtoreg_in, memwrite_in, memread_in, r15_in, regwrite_in;
  logic        flush_ex;
  logic [3:0]  operation;
  logic [15:0] alu_result_out, alu_remainder_out;
  logic        overflow_out;
  logic [3:0]  mov_op_out, exm_reg_rd_out;
  logic        memtoreg_out, memwrite_out, memread_out, r15_out, regwrite_out;

  int tests_run = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct),
    .alu_src(alu_src), .rd1(rd1), .rd2(rd2), .imm(imm),
    .reg_rd(reg_rd), .reg_rt(reg_rt),
    .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .memread_in(memread_in), .r15_in(r15_in),
    .regwrite_in(regwrite_in), .flush_ex(flush_ex),
    .operation(operation), .alu_result_out(alu_result_out),
    .alu_remainder_out(alu_remainder_out),
    .overflow_out(overflow_out), .mov_op_out(mov_op_out),
    .exm_reg_rd_out(exm_reg_rd_out), .memtoreg_out(memtoreg_out),
    .memwrite_out(memwrite_out), .memread_out(memread_out),
    .r15_out(r15_out), .regwrite_out(regwrite_out)
  );

  logic [45:0] regs_o;
  assign regs_o = {alu_result_out, alu_remainder_out, overflow_out,
                   mov_op_out, exm_reg_rd_out, memtoreg_out,
                   memwrite_out, memread_out, r15_out, regwrite_out};

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] res;
    logic [15:0] rem;
    logic        ovf;
  } alu_t;

  function automatic alu_t model_alu();
    alu_t m;
    int a, b, t, sh;
    logic [15:0] bv;
    bit ok;
    bv = alu_src ? imm : rd2;
    a = int'($signed(rd1));
    b = int'($signed(bv));
    sh = int'(bv[3:0]);
    m = '0;
    if (alu_op == 2'd0) m.op = 4'd0;
    else if (alu_op == 2'd1) m.op = 4'd1;
    else if (alu_op == 2'd3) m.op = 4'd12;
    else begin
      ok = (funct <= 4'd3) || (funct >= 4'd8 && funct <= 4'd12);
`ifdef EX_MULDIV_EN
      ok = ok || funct == 4'd4 || funct == 4'd5;
`endif
      m.op = ok ? funct : 4'd15;
    end
    case (m.op)
      4'd0, 4'd1: begin
        t = (m.op == 4'd0) ? a + b : a - b;
        m.res = t[15:0];
        m.ovf = (t > 32767) || (t < -32768);
      end
      4'd2: m.res = rd1 & bv;
      4'd3: m.res = rd1 | bv;
      4'd4: begin
        t = a * b;
        m.res = t[15:0];
        m.rem = t[31:16];
        m.ovf = (t > 32767) || (t < -32768);
      end
      4'd5: begin
        if (b == 0) m.ovf = 1'b1;
        else if (a == -32768 && b == -1) begin
          m.res = 16'h8000;
          m.ovf = 1'b1;
        end else begin
          t = a / b;
          m.res = t[15:0];
          t = a % b;
          m.rem = t[15:0];
        end
      end
      4'd8: begin t = int'(rd1) << sh; m.res = t[15:0]; end
      4'd9: begin t = int'(rd1) >> sh; m.res = t[15:0]; end
      4'd10: begin t = a >>> sh; m.res = t[15:0]; end
      4'd11: begin
        t = (int'(rd1) << sh) | (int'(rd1) >> (16 - sh));
        m.res = t[15:0];
      end
      4'd12: m.res = bv;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [45:0] model_regs();
    alu_t m;
    logic k;
    m = model_alu();
    k = ~flush_ex;
    return {m.res, m.rem, m.ovf & k, reg_rt, reg_rd,
            memtoreg_in & k, memwrite_in & k, memread_in & k,
            r15_in & k, regwrite_in & k};
  endfunction

  task automatic clear_inputs();
    alu_op = 2'b10; funct = 4'd0; alu_src = 1'b0;
    rd1 = '0; rd2 = '0; imm = '0; reg_rd = '0; reg_rt = '0;
    memtoreg_in = 0; memwrite_in = 0; memread_in = 0;
    r15_in = 0; regwrite_in = 0; flush_ex = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    rd1 = 16'h1234; rd2 = 16'h0101; regwrite_in = 1; reg_rd = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (regs_o !== 46'd0) begin
      failed++;
      $display("FAIL reset_state got %h want 0", regs_o);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add_overflow();
    clear_inputs();
    rd1 = 16'h7FFF; rd2 = 16'h0001; regwrite_in = 1;
    #1;
    tests_run++;
    if (operation !== 4'h0) begin
      failed++;
      $display("FAIL add_op got %h want 0", operation);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({alu_result_out, overflow_out, regwrite_out} !== {16'h8000, 2'b11}) begin
      failed++;
      $display("FAIL add_ovf got res=%h ovf=%b rw=%b want 8000 1 1",
               alu_result_out, overflow_out, regwrite_out);
    end
  endtask

  task automatic test_muldiv();
    logic [32:0] want;
    clear_inputs();
    funct = 4'd4; rd1 = 16'h0100; rd2 = 16'h0100;
    #1;
`ifdef EX_MULDIV_EN
    want = {16'h0000, 16'h0001, 1'b1};
`else
    want = 33'd0;
    tests_run++;
    if (operation !== 4'hF) begin
      failed++;
      $display("FAIL mul_disabled_op got %h want f", operation);
    end
`endif
    @(posedge clk); #1;
    tests_run++;
    if ({alu_result_out, alu_remainder_out, overflow_out} !== want) begin
      failed++;
      $display("FAIL mul got %h %h %b want %h",
               alu_result_out, alu_remainder_out, overflow_out, want);
    end
    funct = 4'd5; rd1 = 16'hFFF9; rd2 = 16'h0002;
    @(posedge clk); #1;
`ifdef EX_MULDIV_EN
    want = {16'hFFFD, 16'hFFFF, 1'b0};
`endif
    tests_run++;
    if ({alu_result_out, alu_remainder_out, overflow_out} !== want) begin
      failed++;
      $display("FAIL div_neg got %h %h %b want %h",
               alu_result_out, alu_remainder_out, overflow_out, want);
    end
    rd2 = 16'h0000;
    @(posedge clk); #1;
`ifdef EX_MULDIV_EN
    want = {16'h0000, 16'h0000, 1'b1};
`endif
    tests_run++;
    if ({alu_result_out, alu_remainder_out, overflow_out} !== want) begin
      failed++;
      $display("FAIL div_zero got %h %h %b want %h",
               alu_result_out, alu_remainder_out, overflow_out, want);
    end
    rd1 = 16'h8000; rd2 = 16'hFFFF;
    @(posedge clk); #1;
`ifdef EX_MULDIV_EN
    want = {16'h8000, 16'h0000, 1'b1};
`endif
    tests_run++;
    if ({alu_result_out, alu_remainder_out, overflow_out} !== want) begin
      failed++;
      $display("FAIL div_min got %h %h %b want %h",
               alu_result_out, alu_remainder_out, overflow_out, want);
    end
  endtask

  task automatic test_load_path();
    clear_inputs();
    alu_op = 2'b00; alu_src = 1; rd1 = 16'h0010; rd2 = 16'h5555;
    imm = 16'hFFFE; memread_in = 1; memtoreg_in = 1;
    @(posedge clk); #1;
    tests_run++;
    if ({alu_result_out, memread_out, memtoreg_out} !== {16'h000E, 2'b11}) begin
      failed++;
      $display("FAIL load_addr got %h %b %b want 000e 1 1",
               alu_result_out, memread_out, memtoreg_out);
    end
  endtask

  task automatic test_flush();
    flush_ex = 1; reg_rd = 4'd5; regwrite_in = 1;
    memwrite_in = 1; r15_in = 1;
    @(posedge clk); #1;
    tests_run++;
    if ({memtoreg_out, memwrite_out, memread_out, r15_out,
         regwrite_out, overflow_out} !== 6'd0) begin
      failed++;
      $display("FAIL flush_ctrl got %b want 000000",
               {memtoreg_out, memwrite_out, memread_out, r15_out,
                regwrite_out, overflow_out});
    end
    tests_run++;
    if ({exm_reg_rd_out, alu_result_out} !== {4'd5, 16'h000E}) begin
      failed++;
      $display("FAIL flush_data got rd=%0d res=%h want 5 000e",
               exm_reg_rd_out, alu_result_out);
    end
  endtask

  task automatic test_async_reset();
    logic [45:0] want;
    tests_run++;
    if (regs_o === 46'd0) begin
      failed++;
      $display("FAIL async_preload got 0 want nonzero");
    end
    #3 reset = 1'b0;
    #1;
    tests_run++;
    if (regs_o !== 46'd0) begin
      failed++;
      $display("FAIL async_reset got %h want 0", regs_o);
    end
    flush_ex = 0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (regs_o !== 46'd0) begin
      failed++;
      $display("FAIL reset_hold got %h want 0", regs_o);
    end
    @(negedge clk);
    reset = 1'b1;
    want = model_regs();
    @(posedge clk); #1;
    tests_run++;
    if (regs_o !== want) begin
      failed++;
      $display("FAIL reset_release got %h want %h", regs_o, want);
    end
  endtask

  task automatic test_random();
    alu_t m;
    logic [45:0] want;
    for (int i = 0; i < 400; i++) begin
      alu_op = 2'($urandom);
      funct = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 5))
                                          : 4'($urandom);
      alu_src = 1'($urandom);
      rd1 = 16'($urandom);
      rd2 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rd1 = 16'h8000; rd2 = 16'hFFFF; alu_src = 0;
      end
      imm = 16'($urandom);
      reg_rd = 4'($urandom); reg_rt = 4'($urandom);
      {memtoreg_in, memwrite_in, memread_in, r15_in, regwrite_in} = 5'($urandom);
      flush_ex = ($urandom_range(0, 4) == 0);
      #1;
      m = model_alu();
      want = model_regs();
      tests_run++;
      if (operation !== m.op) begin
        failed++;
        $display("FAIL rand_op[%0d] aop=%b fn=%h got %h want %h",
                 i, alu_op, funct, operation, m.op);
      end
      @(posedge clk); #1;
      tests_run++;
      if (regs_o !== want) begin
        failed++;
        $display("FAIL rand_regs[%0d] op=%h a=%h b=%h got %h want %h",
                 i, m.op, rd1, alu_src ? imm : rd2, regs_o, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_muldiv();
    test_load_path();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
